// File: rtl/pwm_pkg.sv
// Shared PWM definitions: measurement FSM encodings and percent scaling.
// Also imported by pwm_generator, so keep encodings stable.
package pwm_pkg;

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } pwm_state_e;

    localparam int PCT_SCALE = 100;
    localparam int PCT_W     = 7;

endpackage

// File: rtl/pwm_divider.sv
// Restoring unsigned divider, one quotient bit per clk; done pulses N_W
// cycles after start. abort drops an in-flight divide silently.
module pwm_divider #(
    parameter int N_W = 23,
    parameter int D_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient
);

    localparam int SW = $clog2(N_W + 1);

    logic [N_W-1:0] num;
    logic [D_W-1:0] rem;
    logic [D_W-1:0] dvsr;
    logic [SW-1:0]  step;
    logic [D_W:0]   trial;
    logic [D_W-1:0] diff;
    logic           ge;

    // Remainder stays below the divisor, so the low D_W bits of the
    // difference are exact whenever the subtraction is taken.
    assign trial = {rem, num[N_W-1]};
    assign diff  = trial[D_W-1:0] - dvsr;
    assign ge    = (trial >= {1'b0, dvsr});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num  <= '0;
            rem  <= '0;
            dvsr <= '0;
            step <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
                step <= '0;
            end else if (start) begin
                num  <= dividend;
                rem  <= '0;
                dvsr <= divisor;
                step <= SW'(N_W);
                busy <= 1'b1;
            end else if (busy) begin
                rem  <= ge ? diff : trial[D_W-1:0];
                num  <= {num[N_W-2:0], ge};
                step <= step - 1'b1;
                if (step == SW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = num;

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and duty of an asynchronous PWM line, with a
// stuck-line timeout and overrun flag when the duty divider is still busy.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CLOCK_FREQ     = 8_000_000,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 16000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [PCT_W-1:0] duty_pct,
    output logic             valid,
    output logic             stuck,
    output logic             overrun
);

    localparam int               DIV_W   = CNT_W + PCT_W;
    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (CLOCK_FREQ < 1) begin : g_bad_freq
        $error("pwm_capture: CLOCK_FREQ must be positive");
    end

    pwm_state_e       state;
    logic [2:0]       sync_q;
    logic             line, line_q, rise, fall, any_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] op_period, op_high;
    logic [TO_W-1:0]  idle;
    logic             timeout;
    logic             period_done, div_start, div_busy, div_done;
    logic [DIV_W-1:0] div_num, div_q;
    logic [PCT_W-1:0] duty_clamped;

    // Two synchroniser flops plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], pwm_in};
    end

    assign line     = sync_q[1];
    assign line_q   = sync_q[2];
    assign rise     = line & ~line_q;
    assign fall     = ~line & line_q;
    assign any_edge = rise | fall;

    // Restarting at 1 makes the value on the next edge equal the number of
    // clk cycles between the two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (rise)           cnt <= CNT_W'(1);
        else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end

    // Idle counter parks at TIMEOUT_CYCLES so the timeout fires once per run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               idle <= '0;
        else if (any_edge)                        idle <= '0;
        else if (idle != TO_W'(TIMEOUT_CYCLES))   idle <= idle + 1'b1;
    end

    assign timeout     = !any_edge && (idle == TO_W'(TIMEOUT_CYCLES - 1));
    assign period_done = (state == MEAS_LOW) && rise;
    assign div_start   = period_done && !div_busy;
    assign div_num     = DIV_W'(high_q) * DIV_W'(PCT_SCALE);

    pwm_divider #(
        .N_W (DIV_W),
        .D_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (timeout),
        .dividend (div_num),
        .divisor  (cnt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    assign duty_clamped = (div_q > DIV_W'(PCT_SCALE)) ? PCT_W'(PCT_SCALE)
                                                      : div_q[PCT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_EDGE;
            high_q     <= '0;
            op_period  <= '0;
            op_high    <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
            duty_pct   <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= 1'b0;
            if (timeout) begin
                // Already-stuck lines refresh the level but stay silent.
                state      <= WAIT_EDGE;
                stuck      <= 1'b1;
                valid      <= !stuck;
                period_cnt <= '0;
                high_cnt   <= '0;
                duty_pct   <= line_q ? PCT_W'(PCT_SCALE) : '0;
            end else begin
                if (div_done) begin
                    period_cnt <= op_period;
                    high_cnt   <= op_high;
                    duty_pct   <= duty_clamped;
                    valid      <= 1'b1;
                    stuck      <= 1'b0;
                end
                case (state)
                    WAIT_EDGE: if (rise) state <= MEAS_HIGH;
                    MEAS_HIGH: if (fall) begin
                        high_q <= cnt;
                        state  <= MEAS_LOW;
                    end
                    MEAS_LOW: if (rise) begin
                        state <= MEAS_HIGH;
                        if (!div_busy) begin
                            op_period <= cnt;
                            op_high   <= high_q;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= WAIT_EDGE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: default instance plus a narrow-counter
// instance for saturation.
module tb_pwm_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, pwm, pwm_s;
    logic [15:0] period_cnt, high_cnt;
    logic [6:0]  duty_pct;
    logic        valid, stuck, overrun;
    logic [7:0]  s_period, s_high;
    logic [6:0]  s_duty;
    logic        s_valid, s_stuck, s_overrun;

    pwm_capture u_dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm),
        .period_cnt(period_cnt), .high_cnt(high_cnt), .duty_pct(duty_pct),
        .valid(valid), .stuck(stuck), .overrun(overrun)
    );

    pwm_capture #(.CNT_W(8), .TIMEOUT_CYCLES(1000)) u_sat (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_s),
        .period_cnt(s_period), .high_cnt(s_high), .duty_pct(s_duty),
        .valid(s_valid), .stuck(s_stuck), .overrun(s_overrun)
    );

    int          total = 0, bad = 0;
    int          vcnt = 0, ocnt = 0, svcnt = 0, v0, o0;
    logic [15:0] cap_p, cap_h;
    logic [6:0]  cap_d;
    logic [7:0]  scap_p, scap_h;
    logic [6:0]  scap_d;
    bit          chk_d = 1'b0;
    logic [6:0]  exp_d = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive the main line for n cycles, recording every valid/overrun pulse.
    task automatic run(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid) begin
                vcnt++;
                cap_p = period_cnt; cap_h = high_cnt; cap_d = duty_pct;
                if (chk_d) check("duty_each", 32'(duty_pct), 32'(exp_d));
            end
            if (overrun) ocnt++;
            pwm = lvl;
        end
    endtask

    task automatic run_sat(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (s_valid) begin
                svcnt++;
                scap_p = s_period; scap_h = s_high; scap_d = s_duty;
            end
            pwm_s = lvl;
        end
    endtask

    initial begin
        rst_n = 1'b0; pwm = 1'b0; pwm_s = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period", 32'(period_cnt), 0);
        check("rst_high",   32'(high_cnt),   0);
        check("rst_duty",   32'(duty_pct),   0);
        check("rst_flags",  32'({valid, stuck, overrun}), 0);
        rst_n = 1'b1;

        // 1 kHz 25 %: reference edge, then two measured periods
        run(1, 2000); run(0, 6000);
        run(1, 2000);
        check("p25a_vcnt", 32'(vcnt), 1);
        check("p25a_per",  32'(cap_p), 8000);
        check("p25a_high", 32'(cap_h), 2000);
        check("p25a_duty", 32'(cap_d), 25);
        run(0, 6000);
        // 50 % period; its start completes the second 25 % period
        run(1, 4000);
        check("p25b_vcnt", 32'(vcnt), 2);
        check("p25b_per",  32'(cap_p), 8000);
        check("p25b_duty", 32'(cap_d), 25);
        run(0, 4000);
        run(1, 6000);
        check("p50_vcnt", 32'(vcnt), 3);
        check("p50_high", 32'(cap_h), 4000);
        check("p50_duty", 32'(cap_d), 50);
        run(0, 2000);
        run(1, 100);
        check("p75_vcnt", 32'(vcnt), 4);
        check("p75_high", 32'(cap_h), 6000);
        check("p75_duty", 32'(cap_d), 75);
        check("p75_ovr",  32'(ocnt), 0);
        check("p75_stk",  32'(stuck), 0);

        // Held low: just before and just after the timeout
        run(0, 15990);
        check("low_pre_stuck", 32'(stuck), 0);
        run(0, 110);
        check("low_stuck", 32'(stuck), 1);
        check("low_vcnt",  32'(vcnt), 5);
        check("low_duty",  32'(cap_d), 0);
        check("low_per",   32'(period_cnt), 0);
        check("low_high",  32'(high_cnt), 0);
        // Held high: level refreshes, no extra valid while stuck
        run(1, 16100);
        check("high_stuck", 32'(stuck), 1);
        check("high_duty",  32'(duty_pct), 100);
        check("high_per",   32'(period_cnt), 0);
        check("high_vcnt",  32'(vcnt), 5);

        // 10-cycle period, 50 %: 12 completions -> 4 results, 8 overruns
        v0 = vcnt; o0 = ocnt; chk_d = 1'b1; exp_d = 7'd50;
        run(0, 5); run(1, 5);
        for (int k = 0; k < 12; k++) begin
            run(0, 5); run(1, 5);
        end
        run(0, 40);
        chk_d = 1'b0;
        check("fast_vcnt",  32'(vcnt - v0), 4);
        check("fast_ovr",   32'(ocnt - o0), 8);
        check("fast_per",   32'(cap_p), 10);
        check("fast_high",  32'(cap_h), 5);
        check("fast_stuck", 32'(stuck), 0);

        // One-cycle reset in the middle of a divide
        v0 = vcnt;
        run(1, 8);
        @(negedge clk); rst_n = 1'b0; pwm = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("mid_rst_per",  32'(period_cnt), 0);
        check("mid_rst_high", 32'(high_cnt), 0);
        check("mid_rst_duty", 32'(duty_pct), 0);
        check("mid_rst_flag", 32'({valid, stuck, overrun}), 0);
        run(0, 40);
        check("abort_vcnt", 32'(vcnt), 32'(v0));
        run(1, 5); run(0, 5);
        check("one_rise_vcnt", 32'(vcnt), 32'(v0));
        run(1, 40);
        check("two_rise_vcnt", 32'(vcnt), 32'(v0 + 1));
        check("two_rise_per",  32'(cap_p), 10);
        check("two_rise_duty", 32'(cap_d), 50);

        // Narrow counter: period and high both saturate, then period alone
        run_sat(1, 300); run_sat(0, 100);
        run_sat(1, 100);
        check("sat1_vcnt", 32'(svcnt), 1);
        check("sat1_per",  32'(scap_p), 255);
        check("sat1_high", 32'(scap_h), 255);
        check("sat1_duty", 32'(scap_d), 100);
        run_sat(0, 300);
        run_sat(1, 40);
        check("sat2_vcnt",  32'(svcnt), 2);
        check("sat2_per",   32'(scap_p), 255);
        check("sat2_high",  32'(scap_h), 100);
        check("sat2_duty",  32'(scap_d), 39);
        check("sat2_stuck", 32'(s_stuck), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
